// File: rtl/shift_frame_loader.sv
// shift_frame_loader: serializes parallel words into a SISO shift register.
//
// Accepts WIDTH-bit words over a valid/ready handshake and drives the shift
// register's serial inputs one bit per clock until FRAME_BITS bits have been
// shifted. Then it pulses o_frame_done for one cycle.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_start        begin a frame (sampled only in IDLE)
//   i_cfg_dir      frame direction, latched at start (0 MSB-first, 1 LSB-first)
//   i_in_data      word to serialize
//   i_in_valid     i_in_data valid
//   o_in_ready     loader accepts a word this cycle
//   o_sr_en        shift enable to the shift register
//   o_sr_din       serial bit to the shift register
//   o_sr_shift_dir latched direction to the shift register
//   o_busy         high in every state except IDLE
//   o_frame_done   one-cycle pulse after the final frame bit
//   o_bit_count    bits shifted in the current frame (0..FRAME_BITS)
module shift_frame_loader #(
  parameter int unsigned FRAME_BITS = 256,
  parameter int unsigned WIDTH      = 8,
  localparam int unsigned CW        = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_cfg_dir,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_sr_en,
  output logic             o_sr_din,
  output logic             o_sr_shift_dir,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CW-1:0]    o_bit_count
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_word;
  logic [IW-1:0]    r_idx;
  logic             r_dir;
  logic [CW-1:0]    r_count;

  logic w_last_bit;
  logic w_last_frame;
  logic w_in_ready;
  logic w_accept;

  assign w_last_bit   = (r_idx == IW'(WIDTH - 1));
  // bit_count has not yet been bumped for the current shift cycle
  assign w_last_frame = (r_count == CW'(FRAME_BITS - 1));
  assign w_accept     = w_in_ready && i_in_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StLoad;
      end
      StLoad: begin
        if (i_in_valid) w_state_next = StShift;
      end
      StShift: begin
        if (w_last_bit) begin
          if (w_last_frame) begin
            w_state_next = StDone;
          end else if (i_in_valid) begin
            w_state_next = StShift;  // back-to-back word, no sr_en gap
          end else begin
            w_state_next = StLoad;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decode from registers only
  always_comb begin
    w_in_ready   = 1'b0;
    o_sr_en      = 1'b0;
    o_sr_din     = 1'b0;
    o_busy       = 1'b1;
    o_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
      end
      StLoad: begin
        w_in_ready = 1'b1;
      end
      StShift: begin
        o_sr_en    = 1'b1;
        o_sr_din   = r_dir ? r_word[0] : r_word[WIDTH-1];
        w_in_ready = w_last_bit && !w_last_frame;
      end
      StDone: begin
        o_frame_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_in_ready     = w_in_ready;
  assign o_sr_shift_dir = r_dir;
  assign o_bit_count    = r_count;

  // Datapath: word shifter, bit index, direction latch and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
    end else begin
      if (r_state == StIdle && i_start) begin
        r_dir   <= i_cfg_dir;
        r_count <= '0;
      end
      if (w_accept) begin
        r_word <= i_in_data;
        r_idx  <= '0;
      end else if (r_state == StShift) begin
        // The bit on sr_din always sits at the end selected by r_dir
        r_word <= r_dir ? (r_word >> 1) : (r_word << 1);
        r_idx  <= r_idx + IW'(1);
      end
      if (r_state == StShift) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: doc/shift_frame_loader.md
Name: shift_frame_loader

Overview:
Upstream feeder for the 256-bit SISO shift register. It accepts parallel words over a valid/ready handshake and serializes them into the register's din/en/shift_dir inputs, one bit per clock. It counts one full frame of FRAME_BITS bits, then signals completion. This lets the control logic load a whole register image from a byte stream without bit-level sequencing.

Parameters:
FRAME_BITS, 256, number of bits per frame; must be a multiple of WIDTH.
WIDTH, 8, input word width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a frame; sampled only in IDLE.
cfg_dir  input  1  shift direction for the frame (0 left/MSB-first, 1 right/LSB-first); latched at start.
in_data  input  WIDTH  word to serialize.
in_valid  input  1  in_data valid.
in_ready  output  1  loader can accept a word this cycle.
sr_en  output  1  shift enable to the shift register.
sr_din  output  1  serial bit to the shift register.
sr_shift_dir  output  1  latched direction to the shift register.
busy  output  1  high in every state except IDLE.
frame_done  output  1  one-cycle pulse after the final frame bit is shifted.
bit_count  output  clog2(FRAME_BITS+1)  bits shifted in the current frame (0..FRAME_BITS).

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, bit_count=0, internal word and bit index cleared. Deasserting reset mid-frame does not resume the frame; the loader waits for a new start.
- States: IDLE, LOAD, SHIFT, DONE. State, word, index, direction and count are all registers. Outputs decode from registers only, so there is no combinational path from inputs to outputs.
- IDLE: in_ready=0, sr_en=0. On start=1, latch cfg_dir into sr_shift_dir, clear bit_count, and go to LOAD. cfg_dir changes after that cycle have no effect until the next frame.
- LOAD: in_ready=1. On in_valid&&in_ready, capture in_data, clear the bit index, and go to SHIFT. With in_valid=0 the loader stays in LOAD indefinitely with sr_en=0.
- SHIFT: sr_en=1 for exactly WIDTH consecutive cycles per word. bit_count increments by 1 on each of these cycles.
- Bit order in SHIFT:
  - sr_shift_dir=0: sr_din presents word bits WIDTH-1 down to 0.
  - sr_shift_dir=1: sr_din presents word bits 0 up to WIDTH-1.
  - In both cases the first frame bit ends up at the far end of the shift register.
- Back-to-back words: on the last bit cycle of a word (index WIDTH-1), in_ready=1 if bit_count+1 < FRAME_BITS.
  - If a word is accepted then, the next cycle continues SHIFT with the new word, with no sr_en gap.
  - If no word is accepted, go to LOAD.
  - If bit_count+1 == FRAME_BITS, in_ready=0 and the next state is DONE.
- DONE: sr_en=0 and frame_done=1 for exactly one cycle. bit_count holds FRAME_BITS. Next state is IDLE, where bit_count holds its value until the next start.
- start outside IDLE is ignored. in_valid outside LOAD or the last-bit window is ignored and no word is consumed. The source must hold in_data stable while in_valid=1 and in_ready=0.
- Throughput: FRAME_BITS sr_en cycles per frame, at minimum. A streaming source gives start→frame_done = 1 (LOAD) + FRAME_BITS + 1 cycles.
- bit_count never exceeds FRAME_BITS and never wraps.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT at bit 37 → all outputs 0 immediately; after release, in_ready stays 0 until start; the next frame counts from 0.
- Left frame: start with cfg_dir=0, stream 32 words 8'hA5 with in_valid always high → sr_en high for 256 contiguous cycles, sr_din pattern 1,0,1,0,0,1,0,1 repeated; frame_done pulses once, 258 cycles after start; downstream register holds 256'hA5A5…A5.
- Right frame: cfg_dir=1, words 8'h01 then 8'h00 ×31 → first sr_din bit=1 followed by 255 zeros; sr_shift_dir=1 throughout; toggling cfg_dir mid-frame has no effect.
- Throttled source: in_valid high only every 20th cycle → sr_en drops to 0 between words; exactly 8 sr_en cycles per accepted word; bit_count=256 at frame_done; no word lost or duplicated (check with a counting pattern 8'h00..8'h1F).
- Protocol edges: start pulsed during SHIFT is ignored. in_valid held during the DONE cycle → in_ready=0 and the word is not consumed. The next start accepts that same word first.
- Back-to-back frames: start asserted on the cycle after frame_done → the second frame begins cleanly, bit_count restarts at 0, and frame_done pulses exactly twice in total.
